// File: rtl/sq_period_meter.sv
`timescale 1ns/1ps
// sq_period_meter
//   Measures an external square wave, for example a divider output looped back
//   through a pin, in cycles of the local clock. The asynchronous input is
//   synchronised. Period and high time are measured between consecutive rising
//   edges and presented on a valid/ready output. A stalled input raises
//   timeout. A result lost to backpressure sets overrun.
//
// Ports
//   clk          : single clock, posedge
//   rst_n        : asynchronous active-low reset
//   sig_in       : measured signal, asynchronous to clk
//   enable       : 1 = measure, 0 = idle and clear all state
//   period       : clk cycles between two consecutive rising edges
//   high_time    : clk cycles the signal was high within that period
//   meas_valid   : period/high_time hold a result
//   meas_ready   : consumer accepts the result when meas_valid & meas_ready
//   timeout      : no rising edge within TIMEOUT cycles (level)
//   overrun      : sticky, a result was dropped while the previous was unconsumed
//   dbg_state_o  : current FSM state (IDLE=0, WAIT_LOW=1, WAIT_RISE=2, MEASURE=3)
//
// Handshake: a result transfers on every cycle where meas_valid & meas_ready.
// While meas_valid=1 and meas_ready=0, period/high_time hold stable. A new
// capture loads only when the output slot is empty or is being accepted in the
// same cycle. Otherwise the new result is dropped and overrun is set.
module sq_period_meter #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned TIMEOUT     = 1000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             timeout,
  output logic             overrun,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_RISE = 2'd2,
    MEASURE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The timer fires on the cycle it would step onto TIMEOUT, so the timeout flag
  // is visible exactly TIMEOUT cycles after the last rise cycle.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  // Synchroniser plus one delay flop. Both edges pass through the same chain,
  // so its latency cancels in period and high time.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;
  logic                   pipe_low;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  // A genuine low level must be seen through the whole chain. The reset
  // value of the flops is 0, so testing s alone would accept the chain's reset
  // value as a low and let the chain filling up count as a false first rise.
  assign pipe_low = ~|{sync_q, s_d_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= s;
    end
  end

  state_t           state_q;
  logic [CNT_W-1:0] per_cnt_q;   // period counter, doubles as the stall timer
  logic [CNT_W-1:0] hi_cnt_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             valid_q;
  logic             timeout_q;
  logic             overrun_q;
  logic             tmo_hit;

  assign tmo_hit = (per_cnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!enable) begin
      // Disable overrides any capture or timeout in the same cycle.
      state_q   <= IDLE;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // An accepted result empties the slot. A capture below may refill it in
      // the same cycle.
      if (valid_q && meas_ready) begin
        valid_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          state_q <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (tmo_hit) begin
            timeout_q <= 1'b1;
            per_cnt_q <= '0;
          end else begin
            per_cnt_q <= per_cnt_q + CNT_ONE;
            if (pipe_low) begin
              state_q <= WAIT_RISE;
            end
          end
        end
        WAIT_RISE: begin
          if (rise) begin
            state_q   <= MEASURE;
            per_cnt_q <= CNT_ONE;
            hi_cnt_q  <= CNT_ONE;
          end else if (tmo_hit) begin
            state_q   <= WAIT_LOW;
            timeout_q <= 1'b1;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
          end else begin
            per_cnt_q <= per_cnt_q + CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // Capture. The next window starts on this rise cycle (counted high).
            per_cnt_q <= CNT_ONE;
            hi_cnt_q  <= CNT_ONE;
            timeout_q <= 1'b0;
            if (!valid_q || meas_ready) begin
              period_q <= per_cnt_q;
              high_q   <= hi_cnt_q;
              valid_q  <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end else if (tmo_hit) begin
            // Stalled input. Discard the partial window and look for a fresh low.
            state_q   <= WAIT_LOW;
            timeout_q <= 1'b1;
            per_cnt_q <= '0;
            hi_cnt_q  <= '0;
          end else begin
            per_cnt_q <= per_cnt_q + CNT_ONE;
            hi_cnt_q  <= hi_cnt_q + {{(CNT_W-1){1'b0}}, s};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period      = period_q;
  assign high_time   = high_q;
  assign meas_valid  = valid_q;
  assign timeout     = timeout_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule
